// File: rtl/param_memory.sv
// param_memory: byte-enabled word memory behind valid/ready request/response ports; PARAM_MEMORY_OUTPUT_REG_EN adds an output register stage (latency 2).
module param_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2048
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);
  localparam int NB = DATA_W / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd;
  assign in_range = {1'b0, req_addr} < LIM;
  assign idx      = req_addr[AW-1:0];
  assign accept   = req_valid && req_ready;
  assign rd       = in_range && !req_we ? mem[idx] : '0;
  // memory is deliberately not reset so contents survive rst
  always_ff @(posedge clk)
    if (accept && req_we && in_range)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef PARAM_MEMORY_OUTPUT_REG_EN
  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_rdata;
  logic              out_ready;
  assign out_ready = !resp_valid || resp_ready;
  assign req_ready = !rst && !(s1_valid && resp_valid && !resp_ready);
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_err     <= 1'b0;
      s1_rdata   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        s1_rdata <= rd;
        s1_err   <= !in_range;
      end
      s1_valid <= accept || (s1_valid && !out_ready);
      if (out_ready) begin
        resp_valid <= s1_valid;
        resp_rdata <= s1_rdata;
        resp_err   <= s1_err;
      end
    end
`else
  assign req_ready = !rst && (!resp_valid || resp_ready);
  always_ff @(posedge clk)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (!resp_valid || resp_ready) begin
      resp_valid <= accept;
      resp_rdata <= accept ? rd : '0;
      resp_err   <= accept && !in_range;
    end
`endif
endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: directed stimulus checked every cycle against an in-order response model, plus literal expectations.
module tb_param_memory;
`ifdef PARAM_MEMORY_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk, rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [15:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0]  req_be;
  int checks = 0, errors = 0, n = 0;

  param_memory dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic e; bit k; int due; int acc; } exp_t;
  typedef struct { logic [31:0] d; logic e; int t; int lat; } got_t;
  exp_t q[$];
  got_t got[$];
  logic [31:0] mm [2048];
  bit kn [2048];
  bit rst_prev = 1;
  bit exp_v;
  exp_t ne;
  int a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Model: accepted requests queue in order; the head becomes visible LAT cycles after acceptance.
  always @(negedge clk) begin
    n++;
    if (rst) chk("ready_in_rst", req_ready, 0);
    else chk("ready", req_ready, !(q.size() >= LAT && !resp_ready));
    if (rst_prev) begin
      chk("rst_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
    end else begin
      exp_v = q.size() > 0 && q[0].due <= n;
      chk("resp_valid", resp_valid, exp_v);
      if (exp_v && resp_valid) begin
        if (q[0].k) chk("resp_rdata", resp_rdata, q[0].d);
        chk("resp_err", resp_err, q[0].e);
      end
    end
    if (rst) q.delete();
    else begin
      if (resp_valid && resp_ready && q.size() > 0) begin
        got.push_back('{resp_rdata, resp_err, n, n - q[0].acc});
        void'(q.pop_front());
      end
      if (req_valid && req_ready) begin
        a = int'(req_addr);
        ne.e = a >= 2048;
        ne.d = (!req_we && !ne.e) ? mm[a] : 32'h0;
        ne.k = (!req_we && !ne.e) ? kn[a] : 1'b1;
        ne.due = n + LAT;
        ne.acc = n;
        q.push_back(ne);
        if (req_we && !ne.e) begin
          for (int i = 0; i < 4; i++) if (req_be[i]) mm[a][8*i +: 8] = req_wdata[8*i +: 8];
          kn[a] = kn[a] || req_be == 4'hF;
        end
      end
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [15:0] ad, input logic [31:0] d, input logic [3:0] be);
    bit ok;
    ok = 0;
    req_valid = 1; req_we = we; req_addr = ad; req_wdata = d; req_be = be;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    step();
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: addr %h never accepted, required acceptance", ad);
    end
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0;
  endtask

  task automatic exp_r(input string nm, input logic [31:0] d, input logic e, input int lat);
    got_t g;
    int w;
    w = 0;
    while (got.size() == 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (got.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no response, required rdata %h", nm, d);
    end else begin
      g = got.pop_front();
      chk({nm, "_rdata"}, g.d, d);
      chk({nm, "_err"}, {31'b0, g.e}, {31'b0, e});
      if (lat >= 0) chk({nm, "_lat"}, g.lat, lat);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int t0, w;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 1;
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    step();
    // full word write then read-after-write
    issue(1, 5, 32'hDEADBEEF, 4'hF);
    issue(0, 5, 0, 4'hF);
    idle();
    exp_r("w5", 0, 0, LAT);
    exp_r("r5", 32'hDEADBEEF, 0, LAT);
    // byte-enable merge, then all-zero enables
    issue(1, 7, 32'h11223344, 4'hF);
    issue(1, 7, 32'hAABBCCDD, 4'h5);
    issue(0, 7, 0, 4'h0);
    issue(1, 7, 32'hFFFFFFFF, 4'h0);
    issue(0, 7, 0, 4'h0);
    idle();
    exp_r("w7a", 0, 0, LAT);
    exp_r("w7b", 0, 0, LAT);
    exp_r("r7", 32'h11BB33DD, 0, LAT);
    exp_r("w7z", 0, 0, LAT);
    exp_r("r7z", 32'h11BB33DD, 0, LAT);
    // out of range and last in-range word
    issue(1, 0, 32'hCAFEF00D, 4'hF);
    issue(1, 2048, 32'h12345678, 4'hF);
    issue(0, 2048, 0, 4'hF);
    issue(0, 0, 0, 4'hF);
    issue(1, 2047, 32'h0BADCAFE, 4'hF);
    issue(0, 2047, 0, 4'hF);
    idle();
    exp_r("w0", 0, 0, LAT);
    exp_r("woor", 0, 1, LAT);
    exp_r("roor", 0, 1, LAT);
    exp_r("r0", 32'hCAFEF00D, 0, LAT);
    exp_r("w2047", 0, 0, LAT);
    exp_r("r2047", 32'h0BADCAFE, 0, LAT);
    // backpressure
    for (int i = 0; i < 4; i++) issue(1, 16'(10 + i), 32'h100 + i, 4'hF);
    idle();
    for (int i = 0; i < 4; i++) exp_r("wbp", 0, 0, LAT);
    resp_ready = 0;
    issue(0, 10, 0, 4'hF);
    if (LAT == 2) issue(0, 11, 0, 4'hF);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    step();
    step();
    resp_ready = 1;
    for (int i = LAT; i < 4; i++) issue(0, 16'(10 + i), 0, 4'hF);
    idle();
    for (int i = 0; i < 4; i++) exp_r("rbp", 32'h100 + i, 0, -1);
    // reset with a response pending; a write presented during reset must not land
    issue(1, 20, 32'h5A5A1234, 4'hF);
    idle();
    exp_r("w20", 0, 0, LAT);
    resp_ready = 0;
    issue(0, 20, 0, 4'hF);
    idle();
    step();
    step();
    rst = 1;
    req_valid = 1; req_we = 1; req_addr = 20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    step();
    step();
    rst = 0;
    idle();
    resp_ready = 1;
    @(negedge clk);
    chk("ready_after_mid_rst", req_ready, 1);
    step();
    step();
    chk("no_stale_resp", got.size(), 0);
    issue(0, 20, 0, 4'hF);
    idle();
    exp_r("r20_keep", 32'h5A5A1234, 0, LAT);
    // throughput
    for (int i = 0; i < 16; i++) issue(1, 16'(100 + i), 32'h01010101 * (i + 1), 4'hF);
    idle();
    for (int i = 0; i < 16; i++) exp_r("wtp", 0, 0, LAT);
    t0 = n;
    for (int i = 0; i < 16; i++) issue(0, 16'(100 + i), 0, 4'hF);
    chk("thru_accept_cycles", n - t0, 16);
    idle();
    w = 0;
    while (got.size() < 16 && w < 100) begin
      step();
      w++;
    end
    chk("thru_count", got.size(), 16);
    if (got.size() == 16) begin
      t0 = got[0].t;
      for (int i = 0; i < 16; i++) begin
        chk("thru_cycle", got[i].t - t0, i);
        chk("thru_rdata", got[i].d, 32'h01010101 * (i + 1));
      end
    end
    got.delete();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
